// File: rtl/branch_predict_resolve.sv
// Branch predictor and resolver: 2-bit saturating BHT read at fetch, trained at execute,
// with a registered flush/redirect on mispredict and saturating branch statistics.
module branch_predict_resolve #(
  parameter int         ADDR_W   = 32,
  parameter int         IDX_W    = 6,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] pred_pc_i,
  output logic              pred_taken_o,
  input  logic              res_valid_i,
  input  logic [ADDR_W-1:0] res_pc_i,
  input  logic [2:0]        res_cond_i,
  input  logic              res_zero_i,
  input  logic              res_sign_i,
  input  logic              res_pred_taken_i,
  input  logic [ADDR_W-1:0] res_target_i,
  input  logic [ADDR_W-1:0] res_fallthru_i,
  output logic              bt_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  stat_branches_o,
  output logic [CNT_W-1:0]  stat_mispredicts_o
);

  localparam int              ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    COND_NONE   = 3'd0,
    COND_BEQ    = 3'd1,
    COND_BNE    = 3'd2,
    COND_BGEZ   = 3'd3,
    COND_BGTZ   = 3'd4,
    COND_BLEZ   = 3'd5,
    COND_BLTZ   = 3'd6,
    COND_ALWAYS = 3'd7
  } cond_e;

  logic [1:0]        bht_q [ENTRIES];
  logic [1:0]        ctr_d;
  logic [IDX_W-1:0]  pred_idx;
  logic [IDX_W-1:0]  res_idx;
  cond_e             cond;
  logic              active;
  logic              taken;
  logic              mispredict;
  logic              train;
  logic              bt_q, bt_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;
  logic [CNT_W-1:0]  stat_br_q, stat_br_d;
  logic [CNT_W-1:0]  stat_mis_q, stat_mis_d;
  logic              unused_pc_bits;

  // Word-aligned PCs: the byte offset and the bits above the index only alias entries.
  assign unused_pc_bits = ^{pred_pc_i[ADDR_W-1:IDX_W+2], pred_pc_i[1:0],
                            res_pc_i[ADDR_W-1:IDX_W+2], res_pc_i[1:0]};

  assign pred_idx     = pred_pc_i[IDX_W+1:2];
  assign res_idx      = res_pc_i[IDX_W+1:2];
  assign cond         = cond_e'(res_cond_i);
  assign active       = res_valid_i && (cond != COND_NONE);
  assign mispredict   = active && (taken != res_pred_taken_i);
  assign train        = active && (cond != COND_ALWAYS);
  assign pred_taken_o = bht_q[pred_idx][1];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BEQ:    taken = res_zero_i;
      COND_BNE:    taken = ~res_zero_i;
      COND_BGEZ:   taken = ~res_sign_i;
      COND_BGTZ:   taken = ~res_sign_i & ~res_zero_i;
      COND_BLEZ:   taken = res_sign_i | res_zero_i;
      COND_BLTZ:   taken = res_sign_i;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  always_comb begin
    ctr_d = bht_q[res_idx];
    if (taken) begin
      if (bht_q[res_idx] != 2'b11) ctr_d = bht_q[res_idx] + 2'd1;
    end else begin
      if (bht_q[res_idx] != 2'b00) ctr_d = bht_q[res_idx] - 2'd1;
    end
  end

  always_comb begin
    bt_d       = bt_q;
    flush_d    = 1'b0;
    redirect_d = redirect_q;
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (active) begin
      bt_d       = taken;
      flush_d    = mispredict;
      redirect_d = taken ? res_target_i : res_fallthru_i;
      if (stat_br_q != '1) stat_br_d = stat_br_q + CNT_ONE;
      if (mispredict && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + CNT_ONE;
    end
  end

  // Writes land at the edge, so a same-index fetch read sees the old counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= INIT_CTR;
    end else if (train) begin
      bht_q[res_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bt_q       <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      bt_q       <= bt_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign bt_o               = bt_q;
  assign flush_o            = flush_q;
  assign redirect_pc_o      = redirect_q;
  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mis_q;

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor to the single-cycle branch condition resolver, for the pipelined MIPS datapath.
- Holds a branch history table (BHT) of 2-bit saturating counters and gives a combinational taken/not-taken prediction at fetch.
- Resolves the actual branch condition from ALU zero/sign flags at execute, trains the BHT, and issues a registered flush/redirect on mispredict.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- ADDR_W, 32, PC/target width.
- IDX_W, 6, BHT index width; the table has 2**IDX_W entries.
- CNT_W, 16, width of each statistics counter.
- INIT_CTR, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pred_pc  in  ADDR_W  fetch-stage PC.
- pred_taken  out  1  combinational prediction: bit 1 of BHT[pred_pc[IDX_W+1:2]].
- res_valid  in  1  a branch is resolving this cycle.
- res_pc  in  ADDR_W  PC of the resolving branch.
- res_cond  in  3  condition code: 0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7 always.
- res_zero  in  1  ALU zero flag.
- res_sign  in  1  ALU sign flag.
- res_pred_taken  in  1  prediction carried down the pipe with this branch.
- res_target  in  ADDR_W  branch target address.
- res_fallthru  in  ADDR_W  PC+4 of the branch.
- bt  out  1  registered actual outcome of the last resolved branch.
- flush  out  1  registered one-cycle mispredict pulse.
- redirect_pc  out  ADDR_W  registered correct next PC; valid while flush=1.
- stat_branches  out  CNT_W  resolved-branch count.
- stat_mispredicts  out  CNT_W  mispredict count.

Behaviour:
- Reset (synchronous):
  - Every BHT entry is set to INIT_CTR.
  - bt, flush, redirect_pc, stat_branches and stat_mispredicts are set to 0.
  - A flush pending from the cycle before reset is dropped.
- Resolve is active only when res_valid=1 and res_cond≠0. A cycle with res_cond=0 and res_valid=1 is treated as a bubble: no update, no count.
- Actual outcome t:
  - beq: zero.
  - bne: ~zero.
  - bgez: ~sign.
  - bgtz: ~sign & ~zero.
  - blez: sign | zero.
  - bltz: sign.
  - always: 1.
- Timing: resolve inputs are sampled on edge N; bt, flush and redirect_pc are visible after edge N and hold for one cycle (latency 1).
- On each active resolve:
  - bt <= t.
  - flush <= (t ≠ res_pred_taken).
  - redirect_pc <= t ? res_target : res_fallthru.
- On a non-active cycle: flush <= 0. bt and redirect_pc hold their previous values.
- BHT training, conditional codes 1–6 only; the entry is BHT[res_pc[IDX_W+1:2]]:
  - t=1: increment, saturating at 2'b11.
  - t=0: decrement, saturating at 2'b00.
  - Code 7 (always) never writes the BHT.
- Read/write collision: when the pred_pc and res_pc indices are equal in the same cycle, pred_taken shows the pre-update value. There is no bypass.
- Aliasing: PCs that differ only above bit IDX_W+1 share an entry. This is intended.
- Statistics:
  - stat_branches increments on every active resolve.
  - stat_mispredicts increments when a flush is generated.
  - Both saturate at all-ones and do not wrap.
- Back-to-back resolves are supported every cycle; each one produces its own flush decision. Consecutive flush pulses are legal.
- PC bits [1:0] are ignored.

Test Plan:
- Reset, then pred_pc=0x40 -> pred_taken=0. After one beq at 0x40 with zero=1 and res_pred_taken=0 -> next cycle flush=1, redirect_pc=res_target, bt=1, stat_branches=1, stat_mispredicts=1.
- Three taken beq resolves at 0x40 -> counter sequence 01→10→11→11 (saturates); pred_taken=1 from the cycle after the first update.
- Condition sweep, each code against all four (zero, sign) pairs -> bt matches the truth table. In particular bgtz(zero=0, sign=0)=1 and blez(zero=1, sign=0)=1.
- Same-index read/write: pred_pc=res_pc=0x80, counter=01, taken resolve -> pred_taken=0 in that cycle and 1 the cycle after.
- Aliasing and bubbles: PCs 0x100 and 0x100+(4<<IDX_W) share one counter; res_cond=0 with res_valid=1 -> no counter change, flush=0, stats unchanged.
- Reset mid-flush and saturation: assert reset in the cycle a flush is registered -> flush=0 next cycle and all counters back to INIT_CTR. Run 2**CNT_W+3 mispredicts with CNT_W=4 -> both stats hold at 15.
